// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that gives two req/ack writers turns on a shared ff register bank.
// A grant takes IDLE->GRANT->WRITE->ACK (4 cycles). Losing or late requests wait in IDLE. All outputs are registered.
module reg_write_arbiter #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  input  logic             req2,
  input  logic [WIDTH-1:0] d2,
  output logic             ack1,
  output logic             ack2,
  output logic             reg_en,
  output logic [WIDTH-1:0] reg_d,
  output logic             owner,
  output logic             busy,
  output logic [CNT_W-1:0] wr_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, ACK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             ack1_q, ack1_d;
  logic             ack2_q, ack2_d;
  logic             reg_en_q, reg_en_d;
  logic             busy_q, busy_d;
  logic             pick2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      reg_d_q  <= '0;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      ack1_q   <= 1'b0;
      ack2_q   <= 1'b0;
      reg_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      reg_d_q  <= reg_d_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      ack1_q   <= ack1_d;
      ack2_q   <= ack2_d;
      reg_en_q <= reg_en_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    reg_d_d = reg_d_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    // On a tie, requester 2 wins only if requester 1 was served last.
    pick2   = req2 & (~req1 | ~last_q);

    case (state_q)
      IDLE: begin
        if (req1 || req2) begin
          owner_d = pick2;
          hold_d  = pick2 ? d2 : d1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        reg_d_d = hold_q;
        state_d = WRITE;
      end
      WRITE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        last_d  = owner_q;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so they line up with the state register.
    ack1_d   = (state_d == ACK) && !owner_d;
    ack2_d   = (state_d == ACK) && owner_d;
    reg_en_d = (state_d == WRITE);
    busy_d   = (state_d != IDLE);
  end

  assign ack1   = ack1_q;
  assign ack2   = ack2_q;
  assign reg_en = reg_en_q;
  assign reg_d  = reg_d_q;
  assign owner  = owner_q;
  assign busy   = busy_q;
  assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: table-driven transactions, hand-written corner sequences,
// and random two-requester traffic against a timeline reference model.
module tb_reg_write_arbiter;

  localparam int WIDTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req1 = 1'b0, req2 = 1'b0;
  logic [WIDTH-1:0] d1 = '0, d2 = '0;
  logic             ack1, ack2, reg_en, owner, busy;
  logic [WIDTH-1:0] reg_d;
  logic [CNT_W-1:0] wr_cnt;

  int n_chk = 0;
  int n_err = 0;

  reg_write_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req1(req1), .d1(d1), .req2(req2), .d2(d2),
    .ack1(ack1), .ack2(ack2), .reg_en(reg_en), .reg_d(reg_d),
    .owner(owner), .busy(busy), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r1;
    logic [1:0] v1;
    logic       r2;
    logic [1:0] v2;
    logic       own;
    logic [1:0] dat;
    int         cnt;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req1 = 1'b0; req2 = 1'b0;
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    tick();
  endtask

  // Random-phase model state: a grant at edge g puts GRANT/WRITE/ACK in the
  // three cycles after edges g, g+1, g+2; the next grant can be sampled at g+4.
  int         g, en, dd, w1, w2, m_cnt, k, n;
  logic       m_own, m_last;
  logic [1:0] m_dat, m_regd;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b0, 2'b01, 1};
    tbl[1] = '{1'b0, 2'b00, 1'b1, 2'b11, 1'b1, 2'b11, 2};
    tbl[2] = '{1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b10, 3};
    tbl[3] = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 2'b00, 4};
    tbl[4] = '{1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 2'b11, 5};
    tbl[5] = '{1'b0, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01, 6};
    tbl[6] = '{1'b1, 2'b00, 1'b1, 2'b10, 1'b0, 2'b00, 7};
    tbl[7] = '{1'b0, 2'b00, 1'b1, 2'b10, 1'b1, 2'b10, 8};

    apply_reset();
    check("reset busy", busy, 0);
    check("reset reg_en", reg_en, 0);
    check("reset ack1", ack1, 0);
    check("reset ack2", ack2, 0);
    check("reset owner", owner, 0);
    check("reset reg_d", reg_d, 0);
    check("reset wr_cnt", wr_cnt, 0);

    for (int i = 0; i < 8; i++) begin
      req1 = tbl[i].r1; d1 = tbl[i].v1;
      req2 = tbl[i].r2; d2 = tbl[i].v2;
      tick();
      check("tbl grant busy", busy, 1);
      check("tbl grant owner", owner, tbl[i].own);
      check("tbl grant reg_en", reg_en, 0);
      tick();
      check("tbl write reg_en", reg_en, 1);
      check("tbl write reg_d", reg_d, tbl[i].dat);
      check("tbl write acks", {ack1, ack2}, 0);
      tick();
      check("tbl ack1", ack1, !tbl[i].own);
      check("tbl ack2", ack2, tbl[i].own);
      check("tbl ack reg_en", reg_en, 0);
      check("tbl wr_cnt", wr_cnt, tbl[i].cnt);
      if (tbl[i].own) req2 = 1'b0; else req1 = 1'b0;
      tick();
      check("tbl idle busy", busy, 0);
      check("tbl idle reg_d held", reg_d, tbl[i].dat);
    end

    // Data changes after grant must not reach the bank.
    req1 = 1'b1; d1 = 2'b11;
    tick();
    d1 = 2'b00;
    tick();
    check("late data reg_d", reg_d, 3);
    tick();
    check("late data ack1", ack1, 1);
    req1 = 1'b0;
    tick();

    // Request arriving while busy waits for the next IDLE.
    req1 = 1'b1; d1 = 2'b10;
    tick();
    tick();
    req2 = 1'b1; d2 = 2'b01;
    check("busy req write reg_d", reg_d, 2);
    tick();
    check("busy req ack1", ack1, 1);
    check("busy req no ack2", ack2, 0);
    req1 = 1'b0;
    tick();
    check("busy req idle", busy, 0);
    tick();
    check("busy req grant owner", owner, 1);
    tick();
    check("busy req write2 reg_d", reg_d, 1);
    tick();
    check("busy req ack2", ack2, 1);
    check("busy req wr_cnt", wr_cnt, 11);
    req2 = 1'b0;
    tick();

    // Asynchronous reset in the middle of a WRITE cycle.
    req1 = 1'b1; d1 = 2'b10;
    tick();
    tick();
    check("midwrite reg_en before", reg_en, 1);
    rst_n = 1'b0;
    req1 = 1'b0;
    #1;
    check("async rst reg_en", reg_en, 0);
    check("async rst acks", {ack1, ack2}, 0);
    check("async rst wr_cnt", wr_cnt, 0);
    check("async rst busy", busy, 0);
    check("async rst reg_d", reg_d, 0);
    #20;
    rst_n = 1'b1;
    tick();

    // Continuous contention alternates strictly, starting with requester 1.
    apply_reset();
    req1 = 1'b1; d1 = 2'b01;
    req2 = 1'b1; d2 = 2'b10;
    k = 0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      tick();
      if (ack1 || ack2) begin
        check("rr owner", ack2, k % 2);
        k++;
      end
    end
    check("rr writes done", k, 6);
    req1 = 1'b0; req2 = 1'b0;
    tick(); tick(); tick(); tick();

    // Counter wrap over 256 writes.
    apply_reset();
    req1 = 1'b1; d1 = 2'b11;
    n = 0;
    for (int c = 0; c < 1200 && n < 256; c++) begin
      tick();
      if (ack1) begin
        n++;
        check("wrap wr_cnt", wr_cnt, n % 256);
      end
    end
    check("wrap writes done", n, 256);
    req1 = 1'b0;
    tick(); tick(); tick(); tick();

    // Random traffic against the reference model.
    apply_reset();
    g = -100; en = 0; m_last = 1'b1; m_own = 1'b0; m_dat = '0; m_regd = '0;
    m_cnt = 0; w1 = 0; w2 = 0;
    for (int c = 0; c < 800; c++) begin
      en++;
      if (en - g >= 4 && (req1 || req2)) begin
        m_own  = (req1 && req2) ? ~m_last : req2;
        m_dat  = m_own ? d2 : d1;
        m_last = m_own;
        g      = en;
      end
      tick();
      dd = en - g;
      if (dd == 1) m_regd = m_dat;
      if (dd == 2) m_cnt = (m_cnt + 1) % 256;
      check("rnd busy", busy, dd <= 2);
      check("rnd reg_en", reg_en, dd == 1);
      check("rnd ack1", ack1, dd == 2 && !m_own);
      check("rnd ack2", ack2, dd == 2 && m_own);
      check("rnd reg_d", reg_d, m_regd);
      check("rnd wr_cnt", wr_cnt, m_cnt);
      if (dd <= 2) check("rnd owner", owner, m_own);
      if (req1) w1++;
      if (req2) w2++;
      if (dd == 2) begin
        if (m_own) begin
          check("rnd wait2 bound", w2 <= 12, 1);
          req2 = 1'b0; w2 = 0;
        end else begin
          check("rnd wait1 bound", w1 <= 12, 1);
          req1 = 1'b0; w1 = 0;
        end
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; d1 = 2'($urandom_range(0, 3));
      end
      if (!req2 && $urandom_range(0, 2) == 0) begin
        req2 = 1'b1; d2 = 2'($urandom_range(0, 3));
      end
    end
    req1 = 1'b0; req2 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
